lcd_frame_sequencer: RTL and testbench

Controller between the calculator core and the `lcd` HD44780 driver. It holds a 2x16 character frame buffer that the core writes at any time. It repaints dirty display lines and repositions the cursor by issuing one command or character at a time over the `lcd` `d_in` / `data_ready` / `busy_flag` handshake. It also owns the `lcd` reset, so every reset of this block re-runs display initialization.

---
 rtl/lcd_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// lcd_frame_sequencer
//
// Sits between the calculator core and the HD44780 `lcd` driver. Holds a
// 2x16 character frame buffer that the core may write at any time, and
// repaints dirty lines / repositions the cursor one word at a time over the
// lcd d_in / data_ready / busy_flag handshake. This block also owns the lcd
// reset, so every reset here re-runs display initialization and a full
// repaint.
//
// Ports
//   clock            system clock, shared with lcd
//   internal_reset_n synchronous active-low reset
//   wr_en            frame-buffer write strobe
//   wr_addr[4:0]     cell to write: [4] line, [3:0] column
//   wr_char[7:0]     character code to write
//   clr_req          one-cycle pulse: fill buffer with spaces (0x20)
//   cursor_pos[4:0]  cursor cell, same encoding as wr_addr
//   lcd_reset        lcd.internal_reset (active high)
//   lcd_d[8:0]       lcd.d_in: [8] RS, [7:0] data
//   lcd_data_ready   lcd.data_ready, one-cycle pulse per word
//   lcd_busy         lcd.busy_flag
//   ready            init done, nothing dirty, sequencer idle
//
// State     | meaning
// ----------+--------------------------------------------------------------
// RST       | lcd held in reset (also the first cycle after release)
// INIT_HI   | waiting for lcd to raise busy (init running)
// INIT_LO   | waiting for lcd to drop busy (init finished)
// IDLE      | pick next job: line 0 > line 1 > cursor
// ISSUE     | lcd_d valid, data_ready pulsed for exactly this cycle
// WAIT_ACK  | waiting for busy to rise; reissue same word on timeout
// WAIT_DONE | waiting for busy to fall; then next word or back to IDLE

module lcd_frame_sequencer #(
    parameter int ACK_WAIT = 16
) (
    input  logic       clock,
    input  logic       internal_reset_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_char,
    input  logic       clr_req,
    input  logic [4:0] cursor_pos,
    output logic       lcd_reset,
    output logic [8:0] lcd_d,
    output logic       lcd_data_ready,
    input  logic       lcd_busy,
    output logic       ready
);

    localparam int CW = (ACK_WAIT < 2) ? 1 : $clog2(ACK_WAIT);
    localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_WAIT - 1);

    typedef enum logic [2:0] {
        S_RST,
        S_INIT_HI,
        S_INIT_LO,
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    typedef enum logic [1:0] {
        JOB_L0,
        JOB_L1,
        JOB_CUR
    } job_t;

    state_t state;
    state_t state_next;

    logic [7:0] buffer [32];
    logic [1:0] dirty;
    logic       cur_dirty;
    logic [4:0] cur_last;

    job_t          job;
    job_t          job_sel;
    logic          on_addr;     // current word is the line's address command
    logic [3:0]    col;
    logic [3:0]    col_next;
    logic [8:0]    word;
    logic [8:0]    word_next;
    logic [CW-1:0] ack_cnt;
    logic [4:0]    rd_idx;

    logic start_job;
    logic advance;
    logic last_word;
    logic accept;

    assign accept         = (state != S_RST);
    assign lcd_reset      = (state == S_RST);
    assign lcd_data_ready = (state == S_ISSUE);
    assign lcd_d          = word;
    assign ready          = (state == S_IDLE) && (dirty == 2'b00) && !cur_dirty;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!internal_reset_n) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and word selection
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        start_job  = 1'b0;
        advance    = 1'b0;
        job_sel    = JOB_L0;
        word_next  = word;
        col_next   = on_addr ? 4'd0 : (col + 4'd1);
        last_word  = (job == JOB_CUR) || (!on_addr && (col == 4'hF));
        rd_idx     = {(job == JOB_L1), col_next};

        case (state)
            S_RST: begin
                state_next = S_INIT_HI;
            end
            S_INIT_HI: begin
                if (lcd_busy) begin
                    state_next = S_INIT_LO;
                end
            end
            S_INIT_LO: begin
                if (!lcd_busy) begin
                    state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (dirty[0]) begin
                    start_job = 1'b1;
                    job_sel   = JOB_L0;
                    word_next = 9'h080;
                end else if (dirty[1]) begin
                    start_job = 1'b1;
                    job_sel   = JOB_L1;
                    word_next = 9'h0C0;
                end else if (cur_dirty) begin
                    start_job = 1'b1;
                    job_sel   = JOB_CUR;
                    word_next = {1'b0, 1'b1, cursor_pos[4], 2'b00, cursor_pos[3:0]};
                end
                if (start_job) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_next = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (lcd_busy) begin
                    state_next = S_WAIT_DONE;
                end else if (ack_cnt == '0) begin
                    // lcd missed the strobe: repeat the same word
                    state_next = S_ISSUE;
                end
            end
            S_WAIT_DONE: begin
                if (!lcd_busy) begin
                    if (last_word) begin
                        state_next = S_IDLE;
                    end else begin
                        // character is read from the buffer as it is issued,
                        // so late writes to unissued columns still show
                        advance    = 1'b1;
                        word_next  = {1'b1, buffer[rd_idx]};
                        state_next = S_ISSUE;
                    end
                end
            end
            default: begin
                state_next = S_RST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Job tracking, output word and ack timer
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!internal_reset_n) begin
            job     <= JOB_L0;
            on_addr <= 1'b1;
            col     <= 4'd0;
            word    <= 9'h000;
            ack_cnt <= '0;
        end else begin
            if (start_job) begin
                job     <= job_sel;
                on_addr <= 1'b1;
                col     <= 4'd0;
                word    <= word_next;
            end else if (advance) begin
                on_addr <= 1'b0;
                col     <= col_next;
                word    <= word_next;
            end

            if (state == S_ISSUE) begin
                ack_cnt <= ACK_LOAD;
            end else if ((state == S_WAIT_ACK) && (ack_cnt != '0)) begin
                ack_cnt <= ack_cnt - CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer and dirty tracking. Ordering inside the else branch
    // matters: job-start clears come first so a same-cycle write re-marks
    // the line, and the cursor-job capture comes last so the stale
    // cur_last compare cannot re-flag a cursor we are sending right now.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!internal_reset_n) begin
            for (int i = 0; i < 32; i++) begin
                buffer[i] <= 8'h20;
            end
            dirty     <= 2'b11;
            cur_dirty <= 1'b1;
            cur_last  <= 5'd0;
        end else begin
            if (start_job) begin
                case (job_sel)
                    JOB_L0: begin
                        dirty[0]  <= 1'b0;
                        cur_dirty <= 1'b1;
                    end
                    JOB_L1: begin
                        dirty[1]  <= 1'b0;
                        cur_dirty <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            if (accept) begin
                if (cursor_pos != cur_last) begin
                    cur_dirty <= 1'b1;
                end
                if (clr_req) begin
                    for (int i = 0; i < 32; i++) begin
                        buffer[i] <= 8'h20;
                    end
                    dirty <= 2'b11;
                end
                if (wr_en) begin
                    buffer[wr_addr]     <= wr_char;
                    dirty[wr_addr[4]]   <= 1'b1;
                end
            end

            if (start_job && (job_sel == JOB_CUR)) begin
                cur_dirty <= 1'b0;
                cur_last  <= cursor_pos;
            end
        end
    end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed testbench for lcd_frame_sequencer with a small behavioural lcd
// stub: busy rises 2 cycles after a data_ready pulse and stays high for
// BUSY_LEN cycles; after lcd_reset it shows a short init busy window.
module tb_lcd_frame_sequencer;

    localparam int ACK_WAIT_TB = 6;
    localparam int BUSY_LEN    = 3;

    logic       clock = 1'b0;
    logic       internal_reset_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_char;
    logic       clr_req;
    logic [4:0] cursor_pos;
    logic       lcd_reset;
    logic [8:0] lcd_d;
    logic       lcd_data_ready;
    logic       lcd_busy = 1'b0;
    logic       ready;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [8:0] log_q[$];
    int         pulse_cyc[$];
    logic [8:0] exp_q[$];
    logic [7:0] frame[32];

    logic stub_mute = 1'b0;
    logic stub_p1   = 1'b0;
    int   stub_init = 0;
    int   stub_hold = 0;

    always #5 clock = ~clock;

    lcd_frame_sequencer #(.ACK_WAIT(ACK_WAIT_TB)) dut (
        .clock            (clock),
        .internal_reset_n (internal_reset_n),
        .wr_en            (wr_en),
        .wr_addr          (wr_addr),
        .wr_char          (wr_char),
        .clr_req          (clr_req),
        .cursor_pos       (cursor_pos),
        .lcd_reset        (lcd_reset),
        .lcd_d            (lcd_d),
        .lcd_data_ready   (lcd_data_ready),
        .lcd_busy         (lcd_busy),
        .ready            (ready)
    );

    always @(posedge clock) cyc <= cyc + 1;

    // lcd stub
    always @(posedge clock) begin
        if (lcd_reset === 1'b1) begin
            lcd_busy  <= 1'b0;
            stub_init <= 5;
            stub_p1   <= 1'b0;
            stub_hold <= 0;
        end else if (stub_init != 0) begin
            stub_init <= stub_init - 1;
            lcd_busy  <= (stub_init > 1);
        end else begin
            stub_p1 <= (lcd_data_ready === 1'b1) && !stub_mute;
            if (stub_p1) begin
                lcd_busy  <= 1'b1;
                stub_hold <= BUSY_LEN;
            end else if (stub_hold > 1) begin
                stub_hold <= stub_hold - 1;
            end else begin
                lcd_busy  <= 1'b0;
                stub_hold <= 0;
            end
        end
    end

    // transaction monitor
    always @(negedge clock) begin
        if (lcd_data_ready === 1'b1) begin
            log_q.push_back(lcd_d);
            pulse_cyc.push_back(cyc);
        end
    end

    task automatic frame_clear();
        for (int i = 0; i < 32; i++) frame[i] = 8'h20;
    endtask

    task automatic push_line(input int line);
        exp_q.push_back((line != 0) ? 9'h0C0 : 9'h080);
        for (int c = 0; c < 16; c++) exp_q.push_back({1'b1, frame[line*16 + c]});
    endtask

    task automatic wait_ready(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clock);
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        int bad;
        internal_reset_n = 1'b0;
        wr_en = 1'b0; clr_req = 1'b0; wr_addr = 5'd0; wr_char = 8'd0; cursor_pos = 5'd0;
        frame_clear();
        repeat (3) @(negedge clock);
        tests++; if (lcd_reset !== 1'b1) begin fails++; $display("FAIL rst_lcd_reset: got %b want 1", lcd_reset); end
        tests++; if (lcd_data_ready !== 1'b0) begin fails++; $display("FAIL rst_data_ready: got %b want 0", lcd_data_ready); end
        tests++; if (lcd_d !== 9'h000) begin fails++; $display("FAIL rst_lcd_d: got %h want 000", lcd_d); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", ready); end
        @(posedge clock); #1;
        internal_reset_n = 1'b1;
        log_q.delete();
        @(negedge clock);
        tests++; if (lcd_reset !== 1'b1) begin fails++; $display("FAIL rel_hold: lcd_reset got %b want 1", lcd_reset); end
        @(negedge clock);
        tests++; if (lcd_reset !== 1'b0) begin fails++; $display("FAIL rel_drop: lcd_reset got %b want 0", lcd_reset); end
        exp_q.delete();
        push_line(0); push_line(1); exp_q.push_back(9'h080);
        wait_ready(3000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL reset_done: ready never rose"); end
        tests++; if (log_q.size() != exp_q.size()) begin fails++; $display("FAIL reset_count: got %0d words want %0d", log_q.size(), exp_q.size()); end
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
        tests++; if (bad >= 0) begin fails++; $display("FAIL reset_words: word %0d got %h want %h", bad, (bad < log_q.size()) ? log_q[bad] : 9'h1FF, exp_q[bad]); end
    endtask

    task automatic test_single_write();
        bit ok;
        int bad;
        log_q.delete();
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 5'h13; wr_char = 8'h37; cursor_pos = 5'h13;
        @(negedge clock);
        wr_en = 1'b0;
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL wr_ready_low: got %b want 0", ready); end
        frame[5'h13] = 8'h37;
        exp_q.delete();
        push_line(1); exp_q.push_back(9'h0C3);
        wait_ready(1000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL wr_done: ready never rose"); end
        tests++; if (log_q.size() != exp_q.size()) begin fails++; $display("FAIL wr_count: got %0d words want %0d", log_q.size(), exp_q.size()); end
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
        tests++; if (bad >= 0) begin fails++; $display("FAIL wr_words: word %0d got %h want %h", bad, (bad < log_q.size()) ? log_q[bad] : 9'h1FF, exp_q[bad]); end
    endtask

    task automatic test_cursor_only();
        bit ok;
        log_q.delete();
        @(negedge clock);
        cursor_pos = 5'h0A;
        @(negedge clock);
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL cur_ready_low: got %b want 0", ready); end
        wait_ready(500, ok);
        tests++; if (!ok) begin fails++; $display("FAIL cur_done: ready never rose"); end
        tests++; if (log_q.size() != 1) begin fails++; $display("FAIL cur_count: got %0d words want 1", log_q.size()); end
        tests++; if (log_q.size() == 0 || log_q[0] !== 9'h08A) begin fails++; $display("FAIL cur_word: got %h want 08A", (log_q.size() != 0) ? log_q[0] : 9'h1FF); end
    endtask

    task automatic test_write_during_repaint();
        bit ok;
        int bad;
        log_q.delete();
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 5'h00; wr_char = 8'h55;
        @(negedge clock);
        wr_en = 1'b0;
        frame[0] = 8'h55;
        exp_q.delete();
        push_line(0);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (log_q.size() >= 12 && lcd_busy === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        tests++; if (!ok) begin fails++; $display("FAIL wdr_reach_col10: never saw column 10 acked"); end
        @(negedge clock);
        wr_en = 1'b1; wr_addr = 5'h02; wr_char = 8'h62;
        @(negedge clock);
        wr_en = 1'b0;
        frame[2] = 8'h62;
        push_line(0); exp_q.push_back(9'h08A);
        wait_ready(1500, ok);
        tests++; if (!ok) begin fails++; $display("FAIL wdr_done: ready never rose"); end
        bad = -1;
        if (log_q.size() != exp_q.size()) bad = log_q.size();
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
        tests++; if (bad >= 0) begin fails++; $display("FAIL wdr_words: at %0d (got %0d words, want %0d) got %h want %h", bad, log_q.size(), exp_q.size(), (bad < log_q.size()) ? log_q[bad] : 9'h1FF, (bad < exp_q.size()) ? exp_q[bad] : 9'h1FF); end
    endtask

    task automatic test_clear_write();
        bit ok;
        int bad;
        log_q.delete();
        @(negedge clock);
        clr_req = 1'b1; wr_en = 1'b1; wr_addr = 5'h00; wr_char = 8'h41;
        @(negedge clock);
        clr_req = 1'b0; wr_en = 1'b0;
        frame_clear();
        frame[0] = 8'h41;
        exp_q.delete();
        push_line(0); push_line(1); exp_q.push_back(9'h08A);
        wait_ready(3000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL clr_done: ready never rose"); end
        tests++; if (log_q.size() != exp_q.size()) begin fails++; $display("FAIL clr_count: got %0d words want %0d", log_q.size(), exp_q.size()); end
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
        tests++; if (bad >= 0) begin fails++; $display("FAIL clr_words: word %0d got %h want %h", bad, (bad < log_q.size()) ? log_q[bad] : 9'h1FF, exp_q[bad]); end
    endtask

    task automatic test_ack_timeout_and_reset();
        bit ok;
        int bad;
        @(negedge clock);
        stub_mute = 1'b1;
        log_q.delete();
        pulse_cyc.delete();
        wr_en = 1'b1; wr_addr = 5'h05; wr_char = 8'h30;
        @(negedge clock);
        wr_en = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (pulse_cyc.size() >= 3) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        tests++; if (!ok) begin fails++; $display("FAIL to_pulses: got %0d pulses want 3", pulse_cyc.size()); end
        if (ok) begin
            tests++; if (log_q[0] !== 9'h080 || log_q[1] !== 9'h080 || log_q[2] !== 9'h080) begin
                fails++; $display("FAIL to_same_word: got %h %h %h want 080 x3", log_q[0], log_q[1], log_q[2]); end
            tests++; if (pulse_cyc[1] - pulse_cyc[0] != ACK_WAIT_TB + 1) begin
                fails++; $display("FAIL to_period1: got %0d cycles want %0d", pulse_cyc[1] - pulse_cyc[0], ACK_WAIT_TB + 1); end
            tests++; if (pulse_cyc[2] - pulse_cyc[1] != ACK_WAIT_TB + 1) begin
                fails++; $display("FAIL to_period2: got %0d cycles want %0d", pulse_cyc[2] - pulse_cyc[1], ACK_WAIT_TB + 1); end
        end
        stub_mute = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (lcd_busy === 1'b1) begin ok = 1'b1; break; end
        end
        tests++; if (!ok) begin fails++; $display("FAIL mr_ack: busy never rose after unmute"); end
        @(negedge clock);
        internal_reset_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'h00; wr_char = 8'h99;
        @(negedge clock);
        tests++; if (lcd_data_ready !== 1'b0) begin fails++; $display("FAIL mr_data_ready: got %b want 0", lcd_data_ready); end
        tests++; if (lcd_reset !== 1'b1) begin fails++; $display("FAIL mr_lcd_reset: got %b want 1", lcd_reset); end
        tests++; if (lcd_d !== 9'h000) begin fails++; $display("FAIL mr_lcd_d: got %h want 000", lcd_d); end
        tests++; if (ready !== 1'b0) begin fails++; $display("FAIL mr_ready: got %b want 0", ready); end
        @(negedge clock);
        wr_en = 1'b0;
        @(posedge clock); #1;
        internal_reset_n = 1'b1;
        log_q.delete();
        frame_clear();
        exp_q.delete();
        push_line(0); push_line(1); exp_q.push_back(9'h08A);
        wait_ready(3000, ok);
        tests++; if (!ok) begin fails++; $display("FAIL mr_done: ready never rose"); end
        tests++; if (log_q.size() != exp_q.size()) begin fails++; $display("FAIL mr_count: got %0d words want %0d", log_q.size(), exp_q.size()); end
        bad = -1;
        for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && (i >= log_q.size() || log_q[i] !== exp_q[i])) bad = i;
        tests++; if (bad >= 0) begin fails++; $display("FAIL mr_words: word %0d got %h want %h", bad, (bad < log_q.size()) ? log_q[bad] : 9'h1FF, exp_q[bad]); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_cursor_only();
        test_write_during_repaint();
        test_clear_write();
        test_ack_timeout_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
